// File: rtl/uart_encoder.sv
// UART transmitter: a byte FIFO feeding an 8N1/8N2 serialiser.
// The line idles high; queued bytes go out back-to-back with no idle gap.
module uart_encoder #(
    parameter int BAUD_DIV  = 868,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               tx_o,
    output logic               busy_o,
    output logic [FIFO_AW:0]   level_o,
    output logic               overflow_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BW    = $clog2(BAUD_DIV * STOP_BITS);

    localparam logic [BW-1:0]    BIT_LAST   = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0]    STOP_LAST  = BW'(BAUD_DIV * STOP_BITS - 1);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wrPtr;
    logic [FIFO_AW-1:0]   r_rdPtr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_ready;
    logic                 r_overflow;
    logic [7:0]           r_shift;
    logic [BW-1:0]        r_baud;
    logic [2:0]           r_bitIdx;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_notEmpty;
    logic                 w_bitEnd;
    logic                 w_stopEnd;
    logic [FIFO_AW:0]     w_countNext;

    assign w_notEmpty = (r_count != '0);
    assign w_bitEnd   = (r_baud == BIT_LAST);
    assign w_stopEnd  = (r_baud == STOP_LAST);
    assign w_push     = valid_i && r_ready;
    assign w_pop      = w_notEmpty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stopEnd));

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + (FIFO_AW + 1)'(1);
            2'b01:   w_countNext = r_count - (FIFO_AW + 1)'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= data_i;
        end
    end

    // ready is registered from the next count, so a push while full is
    // rejected even if the serialiser pops in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + FIFO_AW'(1);
            end
            r_count <= w_countNext;
            r_ready <= (w_countNext != FULL_COUNT);
            if (valid_i && !r_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_notEmpty) begin
                        r_shift <= r_mem[r_rdPtr];
                        r_baud  <= '0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bitEnd) begin
                        r_baud   <= '0;
                        r_bitIdx <= '0;
                        r_state  <= S_DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bitEnd) begin
                        r_baud <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    // The same counter spans all stop bits before the next frame.
                    if (w_stopEnd) begin
                        r_baud <= '0;
                        if (w_notEmpty) begin
                            r_shift <= r_mem[r_rdPtr];
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign tx_o       = r_tx;
    assign busy_o     = r_busy;
    assign level_o    = r_count;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_uart_encoder.sv
// Bench for uart_encoder: two instances (one and two stop bits) checked every
// cycle against a frame-position model, plus hand-computed frame expectations.
module tb_uart_encoder;

    localparam int BD    = 4;
    localparam int DEPTH = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic       valid1 = 1'b0;
    logic       valid2 = 1'b0;
    logic       ready1, tx1, busy1, ovf1;
    logic       ready2, tx2, busy2, ovf2;
    logic [4:0] level1, level2;

    int compared   = 0;
    int mismatched = 0;

    uart_encoder #(.BAUD_DIV(BD), .STOP_BITS(1), .FIFO_AW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_i(data1), .valid_i(valid1),
        .ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .level_o(level1),
        .overflow_o(ovf1)
    );

    uart_encoder #(.BAUD_DIV(BD), .STOP_BITS(2), .FIFO_AW(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_i(data2), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .level_o(level2),
        .overflow_o(ovf2)
    );

    always #5 clk = ~clk;

    // Model: every accepted byte is appended to a history list; a frame is a
    // position counter from 0 to frame length - 1 over the current byte.
    logic [7:0] mHist [2][256];
    int         mWr [2];
    int         mRd [2];
    bit         mActive [2];
    int         mPos [2];
    logic [7:0] mCur [2];
    bit         mOvf [2];

    function automatic int frameLen(input int d);
        return (9 + ((d == 0) ? 1 : 2)) * BD;
    endfunction

    function automatic int expTx(input int d);
        int p;
        if (!mActive[d]) return 1;
        p = mPos[d];
        if (p < BD) return 0;
        if (p < 9 * BD) return int'(mCur[d][(p - BD) / BD]);
        return 1;
    endfunction

    task automatic modelStep(input int d, input logic v, input logic [7:0] dat);
        int size;
        bit canPush;
        size    = mWr[d] - mRd[d];
        canPush = (size < DEPTH);
        if (mActive[d]) begin
            if (mPos[d] == frameLen(d) - 1) begin
                if (size > 0) begin
                    mCur[d] = mHist[d][mRd[d] & 255];
                    mRd[d]  = mRd[d] + 1;
                    mPos[d] = 0;
                end else begin
                    mActive[d] = 0;
                end
            end else begin
                mPos[d] = mPos[d] + 1;
            end
        end else if (size > 0) begin
            mCur[d]    = mHist[d][mRd[d] & 255];
            mRd[d]     = mRd[d] + 1;
            mActive[d] = 1;
            mPos[d]    = 0;
        end
        if (v) begin
            if (canPush) begin
                mHist[d][mWr[d] & 255] = dat;
                mWr[d] = mWr[d] + 1;
            end else begin
                mOvf[d] = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mWr[d] = 0; mRd[d] = 0; mActive[d] = 0;
                mPos[d] = 0; mCur[d] = '0; mOvf[d] = 0;
            end
        end else begin
            modelStep(0, valid1, data1);
            modelStep(1, valid2, data2);
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int getTx(input int d);    return (d == 0) ? int'(tx1) : int'(tx2); endfunction
    function automatic int getBusy(input int d);  return (d == 0) ? int'(busy1) : int'(busy2); endfunction
    function automatic int getLevel(input int d); return (d == 0) ? int'(level1) : int'(level2); endfunction
    function automatic int getReady(input int d); return (d == 0) ? int'(ready1) : int'(ready2); endfunction
    function automatic int getOvf(input int d);   return (d == 0) ? int'(ovf1) : int'(ovf2); endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("dut%0d.tx", d + 1), getTx(d), expTx(d));
            checkOutput($sformatf("dut%0d.busy", d + 1), getBusy(d), int'(mActive[d]));
            checkOutput($sformatf("dut%0d.level", d + 1), getLevel(d), mWr[d] - mRd[d]);
            checkOutput($sformatf("dut%0d.ready", d + 1), getReady(d),
                        int'((mWr[d] - mRd[d]) < DEPTH));
            checkOutput($sformatf("dut%0d.overflow", d + 1), getOvf(d), int'(mOvf[d]));
        end
    end

    logic       capTx [0:99];
    logic       capBusy [0:99];
    int         capLevel [0:99];
    logic [7:0] burst [0:31];

    task automatic applyStimulus(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            if (d == 0) begin valid1 = 1'b1; data1 = burst[i]; end
            else        begin valid2 = 1'b1; data2 = burst[i]; end
            @(negedge clk);
        end
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    task automatic captureFrame(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            capTx[k]    = logic'(getTx(d));
            capBusy[k]  = logic'(getBusy(d));
            capLevel[k] = getLevel(d);
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input int d);
        int n = 0;
        while ((getBusy(d) != 0 || getLevel(d) != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitIdle.inBudget", int'(n < 3000), 1);
    endtask

    task automatic waitStart(input int d, input int expLat);
        int n = 0;
        while (getTx(d) == 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("startLatency", n, expLat);
    endtask

    function automatic logic [7:0] decodeByte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = capTx[base + BD + BD * i + BD / 2];
        return b;
    endfunction

    function automatic int countBusy(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (capBusy[k]) c++;
        return c;
    endfunction

    initial begin
        int bad;
        int ones;

        repeat (3) @(negedge clk);
        checkOutput("reset.tx", int'(tx1), 1);
        checkOutput("reset.busy", int'(busy1), 0);
        checkOutput("reset.ready", int'(ready1), 1);
        checkOutput("reset.level", int'(level1), 0);
        checkOutput("reset.overflow", int'(ovf1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 0x55 frame: start one cycle after the write, busy for 40 cycles.
        burst[0] = 8'h55;
        applyStimulus(0, 1);
        waitStart(0, 1);
        captureFrame(0, 45);
        checkOutput("single.startFirst", int'(capTx[0]), 0);
        checkOutput("single.startLast", int'(capTx[3]), 0);
        checkOutput("single.byte", int'(decodeByte(0)), 8'h55);
        checkOutput("single.stop", int'(capTx[39]), 1);
        checkOutput("single.busyCycles", countBusy(45), 40);
        checkOutput("single.busyFalls", int'(capBusy[40]), 0);

        // Back-to-back 0xA5, 0x3C: second start exactly 40 cycles after the first.
        waitIdle(0);
        burst[0] = 8'hA5;
        burst[1] = 8'h3C;
        applyStimulus(0, 2);
        waitStart(0, 0);
        captureFrame(0, 85);
        checkOutput("b2b.byte0", int'(decodeByte(0)), 8'hA5);
        checkOutput("b2b.byte1", int'(decodeByte(40)), 8'h3C);
        checkOutput("b2b.stopBefore2nd", int'(capTx[39]), 1);
        checkOutput("b2b.start2nd", int'(capTx[40]), 0);
        checkOutput("b2b.levelInitial", capLevel[0], 1);
        checkOutput("b2b.levelBeforePop", capLevel[39], 1);
        checkOutput("b2b.levelAfterPop", capLevel[40], 0);
        checkOutput("b2b.busyCycles", countBusy(85), 80);

        // 18 consecutive writes while idle: 17 accepted, the last one dropped.
        waitIdle(0);
        for (int i = 0; i < 18; i++) begin
            if (i == 16) checkOutput("full.readyAt15", int'(ready1), 1);
            if (i == 17) begin
                checkOutput("full.readyLow", int'(ready1), 0);
                checkOutput("full.level16", int'(level1), 16);
            end
            valid1 = 1'b1;
            data1  = 8'(16 + i);
            @(negedge clk);
        end
        valid1 = 1'b0;
        checkOutput("full.overflowSet", int'(ovf1), 1);
        checkOutput("full.levelAfter", int'(level1), 16);
        repeat (24) @(negedge clk);
        for (int f = 1; f <= 16; f++) begin
            captureFrame(0, 40);
            checkOutput($sformatf("full.start%0d", f), int'(capTx[0]), 0);
            checkOutput($sformatf("full.byte%0d", f), int'(decodeByte(0)), 16 + f);
        end
        checkOutput("full.idleAfter", int'(busy1), 0);
        checkOutput("full.overflowSticky", int'(ovf1), 1);

        // Two stop bits: 4 low, 40 high, next start 44 cycles after the first.
        burst[0] = 8'hFF;
        burst[1] = 8'hFF;
        applyStimulus(1, 2);
        waitStart(1, 0);
        captureFrame(1, 90);
        checkOutput("stop2.start", int'(capTx[3]), 0);
        ones = 0;
        for (int k = 4; k < 44; k++) if (capTx[k]) ones++;
        checkOutput("stop2.highRun", ones, 40);
        checkOutput("stop2.start2nd", int'(capTx[44]), 0);
        checkOutput("stop2.byte1", int'(decodeByte(44)), 8'hFF);
        checkOutput("stop2.busyCycles", countBusy(90), 88);

        // Reset during data bit 3 with five bytes queued.
        waitIdle(0);
        for (int i = 0; i < 6; i++) burst[i] = 8'(8'h60 + i);
        applyStimulus(0, 6);
        checkOutput("rst.levelQueued", int'(level1), 5);
        repeat (12) @(negedge clk);
        checkOutput("rst.busyBefore", int'(busy1), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst.txHigh", int'(tx1), 1);
        checkOutput("rst.busyLow", int'(busy1), 0);
        checkOutput("rst.levelZero", int'(level1), 0);
        checkOutput("rst.overflowClear", int'(ovf1), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        checkOutput("rst.noSpuriousStart", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
